sync_fifo_ext: RTL and testbench

SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

---
 rtl/sync_fifo_ext.sv | 135 +++++++++++++
 tb/tb_sync_fifo_ext.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with registered status flags and one-cycle error pulses.
// Define SYNC_FIFO_EXT_FWFT_EN for first-word-fall-through read mode.
//
// Ports:
//   clk          : clock; all state updates on the rising edge
//   rst_n        : synchronous active-low reset
//   wr_en        : write request, accepted when not full
//   data_in      : write data
//   rd_en        : read request, accepted when not empty
//   data_out     : read data (registered, or head entry in FWFT mode)
//   full, empty  : count==DEPTH / count==0
//   almost_full  : count>=AF_LEVEL
//   almost_empty : count<=AE_LEVEL
//   count        : current occupancy, 0..DEPTH
//   overflow     : one-cycle pulse after a rejected write
//   underflow    : one-cycle pulse after a rejected read
module sync_fifo_ext #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance looks only at the registered flags, so a read that frees
  // a slot never lets a same-cycle write into a full FIFO.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (count_d == FULL_L);
    empty_d  = (count_d == '0);
    af_d     = (count_d >= AF_L);
    ae_d     = (count_d <= AE_L);
    ovf_d    = wr_en && full_q;
    unf_d    = rd_en && empty_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_L == '0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_EXT_FWFT_EN
  // Head entry is presented directly; masked to zero while empty.
  assign data_out = empty_q ? '0 : mem[rd_ptr_q];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rd_ptr_q];
    end
  end

  assign data_out = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Testbench for sync_fifo_ext: vector table plus scoreboard sequences.
// Works in both read modes (SYNC_FIFO_EXT_FWFT_EN defined or not).
module tb_sync_fifo_ext;

  localparam int W = 16;
  localparam int D = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [W-1:0] data_in;
  logic         rd_en;
  logic [W-1:0] data_out;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;

  sync_fifo_ext #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    int           cnt;
    logic         ovf;
    logic         unf;
  } vec_t;

  int n_vec;
  int n_err;

  logic [W-1:0] q[$];
  int           m_count;
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("count", int'(count), m_count);
    chk("full", int'(full), int'(m_count == D));
    chk("empty", int'(empty), int'(m_count == 0));
    chk("almost_full", int'(almost_full), int'(m_count >= AF));
    chk("almost_empty", int'(almost_empty), int'(m_count <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`ifdef SYNC_FIFO_EXT_FWFT_EN
    if (m_count != 0) chk("data_out", int'(data_out), int'(q[0]));
`else
    chk("data_out", int'(data_out), int'(m_dout));
`endif
  endtask

  // One clock: drive, update the reference model, sample after the edge.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [W-1:0] din);
    logic wa;
    logic ra;
    rst_n   = ~rst;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    wa = wr && (m_count != D);
    ra = rd && (m_count != 0);
    if (rst) begin
      q.delete();
      m_count = 0;
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_ovf = wr && (m_count == D);
      m_unf = rd && (m_count == 0);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
      m_count = m_count + int'(wa) - int'(ra);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  vec_t vt[9];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_count = 0;
    m_dout  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;

    vt[0] = '{1'b1, 1'b1, 16'hABCD, 1, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b0, 16'h0011, 1, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'h0022, 2, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 16'h0033, 2, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0};

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_data_out", int'(data_out), 0);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      step(1'b0, vt[i].wr, vt[i].rd, vt[i].din);
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].cnt);
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vt[i].ovf));
      chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vt[i].unf));
    end

    // Fill to full, then one rejected write
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 1'b1, 1'b0, W'(i));
      chk("fill_af", int'(almost_full), int'(i >= 14));
    end
    chk("full_flag", int'(full), 1);
    step(1'b0, 1'b1, 1'b0, 16'h0011);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), D);
    idle();
    chk("ovf_clear", int'(overflow), 0);

    // Drain in order, then one rejected read
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_EXT_FWFT_EN
      chk("drain_order", int'(data_out), i);
`endif
    end
    chk("drain_empty", int'(empty), 1);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("unf_pulse", int'(underflow), 1);
`ifndef SYNC_FIFO_EXT_FWFT_EN
    chk("unf_hold", int'(data_out), 16'h0010);
`endif
    idle();
    chk("unf_clear", int'(underflow), 0);

    // Fill 8 then streaming read/write across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0100 + i));
    for (int i = 8; i < 48; i++) begin
      step(1'b0, 1'b1, 1'b1, W'(16'h0100 + i));
`ifndef SYNC_FIFO_EXT_FWFT_EN
      chk("stream_seq", int'(data_out), 16'h0100 + i - 8);
`endif
    end
    chk("stream_count", int'(count), 8);

    // Full with both requests: read wins, write rejected
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0200 + i));
    chk("full_again", int'(full), 1);
    step(1'b0, 1'b1, 1'b1, 16'hDEAD);
    chk("full_both_cnt", int'(count), D - 1);
    chk("full_both_ovf", int'(overflow), 1);
    while (m_count != 0) step(1'b0, 1'b0, 1'b1, '0);

    // Reset mid-operation with a pending write
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0300 + i));
    step(1'b1, 1'b1, 1'b0, 16'h5555);
    chk("midrst_count", int'(count), 0);
    chk("midrst_ovf", int'(overflow), 0);
    step(1'b0, 1'b1, 1'b0, 16'h1234);
`ifdef SYNC_FIFO_EXT_FWFT_EN
    chk("midrst_fwft", int'(data_out), 16'h1234);
`endif
    step(1'b0, 1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_EXT_FWFT_EN
    chk("midrst_read", int'(data_out), 16'h1234);
`endif

`ifdef SYNC_FIFO_EXT_FWFT_EN
    // Fall-through visibility without rd_en
    step(1'b0, 1'b1, 1'b0, 16'h00AA);
    chk("fwft_show", int'(data_out), 16'h00AA);
    idle();
    chk("fwft_hold", int'(data_out), 16'h00AA);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("fwft_empty", int'(empty), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
